// File: rtl/dct8_stream.sv
// ---------------------------------------------------------------------------
// dct8_stream
//
// Streaming 8-point DCT. Samples arrive one per cycle on a valid/ready port
// and are grouped into blocks of 8. Each block goes through three registered
// butterfly stages with Q9 coefficients. The 8 coefficients then leave
// serially on a valid/ready port.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low reset
//   s_valid  input sample valid
//   s_ready  sample accepted this cycle (combinational)
//   s_data   W-bit signed input sample
//   m_valid  output coefficient valid
//   m_ready  downstream accepts the coefficient
//   m_data   W-bit signed output coefficient
//   m_last   high on the 8th coefficient of a block
//
// Build option:
//   DCT8_SAT_EN  when defined, every stage output clamps to the W-bit signed
//                range. When undefined, each stage output keeps its low W bits
//                and wraps in two's complement.
// ---------------------------------------------------------------------------
module dct8_stream #(
  parameter int W = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [W-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [W-1:0] m_data,
  output logic                m_last
);

  // The product is kept W+11 bits wide so a W+1 bit difference times a
  // 9-bit coefficient never overflows before the rounding shift.
  localparam int PW = W + 11;

  typedef logic signed [W-1:0] word_t;

  localparam logic signed [PW-1:0] ROUND   = PW'(256);
  localparam logic signed [PW-1:0] SAT_MAX = {{12{1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{12{1'b1}}, {(W-1){1'b0}}};

  localparam logic [8:0] C_S1  = 9'd362;
  localparam logic [8:0] C_S2U = 9'd473;
  localparam logic [8:0] C_S2L = 9'd196;
  localparam logic [8:0] C_S3 [4] = '{9'd502, 9'd50, 9'd425, 9'd284};

  // Brings a full-width intermediate back to W bits.
  function automatic word_t reduce(input logic signed [PW-1:0] v);
`ifdef DCT8_SAT_EN
    if (v > SAT_MAX)
      reduce = SAT_MAX[W-1:0];
    else if (v < SAT_MIN)
      reduce = SAT_MIN[W-1:0];
    else
      reduce = v[W-1:0];
`else
    reduce = v[W-1:0];
`endif
  endfunction

  function automatic word_t bf_top(input word_t t, input word_t b);
    logic signed [W:0]    sum;
    logic signed [PW-1:0] ext;
    sum = {t[W-1], t} + {b[W-1], b};
    ext = {{10{sum[W]}}, sum};
    bf_top = reduce(ext);
  endfunction

  // Rounded Q9 multiply of the difference: add half an LSB, then shift
  // arithmetically so negative values round the same way as positive ones.
  function automatic word_t bf_bot(input word_t t, input word_t b,
                                   input logic [8:0] c);
    logic signed [W:0]    diff;
    logic signed [PW-1:0] de;
    logic signed [PW-1:0] ce;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd;
    diff = {t[W-1], t} - {b[W-1], b};
    de   = {{10{diff[W]}}, diff};
    ce   = {{(PW-9){1'b0}}, c};
    prod = de * ce;
    rnd  = prod + ROUND;
    bf_bot = reduce(rnd >>> 9);
  endfunction

  // Collector state
  word_t      d [7];
  logic [2:0] count;

  // Pipeline state
  word_t s1_q [8];
  word_t s2_q [8];
  word_t s3_q [8];
  logic  s1_valid;
  logic  s2_valid;
  logic  s3_valid;

  // Output buffer state
  word_t      obuf [8];
  logic [2:0] idx;

  // Combinational stage results
  word_t blk   [8];
  word_t s1_nx [8];
  word_t s2_nx [8];
  word_t s3_nx [8];

  logic en;
  logic load;
  logic s_hs;
  logic blk_in;
  logic m_hs;

  // A new block may enter the buffer when it is idle or its last word is
  // leaving this very cycle. The whole cascade only moves when s3 is empty
  // or is being handed to the buffer, so one enable serves all stages.
  assign load   = s3_valid && (!m_valid || (m_ready && idx == 3'd7));
  assign en     = !s3_valid || load;
  assign s_ready = (count != 3'd7) || en;
  assign s_hs   = s_valid && s_ready;
  assign blk_in = s_hs && (count == 3'd7);
  assign m_hs   = m_valid && m_ready;

  assign m_data = obuf[idx];
  assign m_last = m_valid && (idx == 3'd7);

  // The 8th sample bypasses the collector and feeds stage 1 directly.
  always_comb begin
    for (int i = 0; i < 7; i++)
      blk[i] = d[i];
    blk[7] = s_data;

    for (int i = 0; i < 4; i++) begin
      s1_nx[i]     = bf_top(blk[i], blk[i+4]);
      s1_nx[i + 4] = bf_bot(blk[i], blk[i+4], C_S1);
    end

    // Stage 2 output order within a half: top(0,2), top(1,3), bot(0,2), bot(1,3)
    for (int h = 0; h < 2; h++) begin
      for (int j = 0; j < 2; j++) begin
        s2_nx[4*h + j]     = bf_top(s1_q[4*h + j], s1_q[4*h + j + 2]);
        s2_nx[4*h + 2 + j] = bf_bot(s1_q[4*h + j], s1_q[4*h + j + 2],
                                    (h == 0) ? C_S2U : C_S2L);
      end
    end

    for (int g = 0; g < 4; g++) begin
      s3_nx[2*g]     = bf_top(s2_q[2*g], s2_q[2*g + 1]);
      s3_nx[2*g + 1] = bf_bot(s2_q[2*g], s2_q[2*g + 1], C_S3[g]);
    end
  end

  // Collector: samples 0..6 of a block are parked in d[], the 8th one
  // completes the block and the count wraps back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      d     <= '{default: '0};
    end else if (s_hs) begin
      if (count == 3'd7) begin
        count <= '0;
      end else begin
        for (int i = 0; i < 7; i++)
          if (count == 3'(i))
            d[i] <= s_data;
        count <= count + 3'd1;
      end
    end
  end

  // Butterfly cascade, all stages advancing together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '{default: '0};
      s2_q     <= '{default: '0};
      s3_q     <= '{default: '0};
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= blk_in;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (blk_in)
        s1_q <= s1_nx;
      if (s1_valid)
        s2_q <= s2_nx;
      if (s2_valid)
        s3_q <= s3_nx;
    end
  end

  // Output buffer: a load takes priority over retiring the last word, so a
  // following block streams out without a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      obuf    <= '{default: '0};
      idx     <= '0;
      m_valid <= 1'b0;
    end else if (load) begin
      obuf    <= s3_q;
      idx     <= '0;
      m_valid <= 1'b1;
    end else if (m_hs) begin
      if (idx != 3'd7)
        idx <= idx + 3'd1;
      else
        m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dct8_stream.sv
// ---------------------------------------------------------------------------
// tb_dct8_stream
//
// Self-checking bench for dct8_stream. Outputs are compared against
// fixed values for the impulse, DC and overflow blocks, and against a
// behavioural DCT model for random blocks. Inputs change 1 time unit after
// the rising edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_dct8_stream;

  localparam int W = 18;

  typedef longint blk_t [8];

  logic                clk = 1'b0;
  logic                reset;
  logic                s_valid;
  logic                s_ready;
  logic signed [W-1:0] s_data;
  logic                m_valid;
  logic                m_ready;
  logic signed [W-1:0] m_data;
  logic                m_last;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accepted = 0;
  int last_acc_cyc = 0;

  longint got_data [$];
  bit     got_last [$];
  int     got_cyc  [$];

  dct8_stream #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every output handshake that will complete at the next edge.
  always @(negedge clk) begin
    logic signed [W-1:0] md;
    if (reset && m_valid && m_ready) begin
      md = m_data;
      got_data.push_back(longint'(md));
      got_last.push_back(m_last);
      got_cyc.push_back(cyc);
    end
  end

  // ---------------- behavioural reference ----------------
  function automatic longint red(input longint v);
    longint half;
    longint full;
    longint m;
    half = longint'(1) <<< (W - 1);
    full = longint'(1) <<< W;
`ifdef DCT8_SAT_EN
    if (v > half - 1) return half - 1;
    if (v < -half)    return -half;
    return v;
`else
    m = v & (full - 1);
    if (m >= half) m = m - full;
    return m;
`endif
  endfunction

  function automatic longint top(input longint t, input longint b);
    return red(t + b);
  endfunction

  function automatic longint bot(input longint t, input longint b, input longint c);
    return red(((t - b) * c + 256) >>> 9);
  endfunction

  task automatic dct_ref(input blk_t x, output blk_t y);
    longint a [8];
    longint b [8];
    longint c3 [4];
    c3 = '{502, 50, 425, 284};
    for (int i = 0; i < 4; i++) begin
      a[i]     = top(x[i], x[i+4]);
      a[i + 4] = bot(x[i], x[i+4], 362);
    end
    for (int h = 0; h < 2; h++)
      for (int j = 0; j < 2; j++) begin
        b[4*h + j]     = top(a[4*h + j], a[4*h + j + 2]);
        b[4*h + 2 + j] = bot(a[4*h + j], a[4*h + j + 2], (h == 0) ? 473 : 196);
      end
    for (int g = 0; g < 4; g++) begin
      y[2*g]     = top(b[2*g], b[2*g + 1]);
      y[2*g + 1] = bot(b[2*g], b[2*g + 1], c3[g]);
    end
  endtask

  function automatic longint rand_sample();
    logic signed [W-1:0] r;
    r = W'($urandom);
    return longint'(r);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input longint xs [$], input int gap_pct);
    int     waited;
    longint v;
    foreach (xs[k]) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      v = xs[k];
      s_valid = 1'b1;
      s_data  = v[W-1:0];
      waited  = 0;
      @(negedge clk);
      while (!s_ready && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (!s_ready) begin
        checks++; errors++;
        $display("[TB] FAIL send_timeout: sample %0d not accepted, s_ready=%0b required 1", k, s_ready);
        s_valid = 1'b0;
        return;
      end
      last_acc_cyc = cyc;
      @(posedge clk); #1;
      accepted++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int waited;
    waited = 0;
    while (got_data.size() < n && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (got_data.size() < n) begin
      checks++; errors++;
      $display("[TB] FAIL word_timeout: got %0d words, required %0d", got_data.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
    got_cyc.delete();
  endtask

  task automatic push_block(ref longint q [$], input blk_t b);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid: got %0b required 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("[TB] FAIL reset_m_data: got %0d required 0", m_data); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last: got %0b required 0", m_last); end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready: got %0b required 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    longint xs [$];
    longint exp_w [8];
    exp_w = '{512, 502, 473, 46, 362, 300, 139, 77};
    xs = '{512, 0, 0, 0, 0, 0, 0, 0};
    clear_got();
    m_ready = 1'b1;
    applyStimulus(xs, 0);
    wait_words(8);
    if (got_data.size() >= 8) begin
      checks++;
      if (got_cyc[0] !== last_acc_cyc + 4) begin
        errors++; $display("[TB] FAIL impulse_latency: got cycle %0d required %0d", got_cyc[0], last_acc_cyc + 4);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_data[i] !== exp_w[i]) begin
          errors++; $display("[TB] FAIL impulse_word%0d: got %0d required %0d", i, got_data[i], exp_w[i]);
        end
        checks++;
        if (got_last[i] !== (i == 7)) begin
          errors++; $display("[TB] FAIL impulse_last%0d: got %0b required %0b", i, got_last[i], (i == 7));
        end
      end
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (got_data.size() !== 8) begin
      errors++; $display("[TB] FAIL impulse_count: got %0d words required 8", got_data.size());
    end
  endtask

  task automatic test_dc();
    longint xs [$];
    xs = '{100, 100, 100, 100, 100, 100, 100, 100};
    clear_got();
    applyStimulus(xs, 0);
    wait_words(8);
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== ((i == 0) ? 64'sd800 : 64'sd0)) begin
        errors++; $display("[TB] FAIL dc_word%0d: got %0d required %0d", i, got_data[i], (i == 0) ? 800 : 0);
      end
    end
  endtask

  task automatic test_overflow();
    longint xs [$];
    longint w0;
`ifdef DCT8_SAT_EN
    w0 = 131071;
`else
    w0 = -8;
`endif
    xs = '{131071, 131071, 131071, 131071, 131071, 131071, 131071, 131071};
    clear_got();
    applyStimulus(xs, 0);
    wait_words(8);
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== ((i == 0) ? w0 : 64'sd0)) begin
        errors++; $display("[TB] FAIL overflow_word%0d: got %0d required %0d", i, got_data[i], (i == 0) ? w0 : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    longint xs [$];
    longint exp_w [8];
    int     nlast;
    exp_w = '{512, 502, 473, 46, 362, 300, 139, 77};
    xs.delete();
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 8; i++) xs.push_back((i == 0) ? 512 : 0);
    clear_got();
    accepted = 0;
    m_ready = 1'b0;
    fork
      applyStimulus(xs, 0);
      begin
        repeat (40) @(negedge clk);
        checks++;
        if (accepted !== 23) begin
          errors++; $display("[TB] FAIL bp_accepted: got %0d required 23", accepted);
        end
        checks++;
        if (s_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL bp_s_ready: got %0b required 0", s_ready);
        end
        @(posedge clk); #1 m_ready = 1'b1;
      end
    join
    wait_words(24);
    nlast = 0;
    for (int i = 0; i < 24 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_w[i % 8]) begin
        errors++; $display("[TB] FAIL bp_word%0d: got %0d required %0d", i, got_data[i], exp_w[i % 8]);
      end
      if (got_last[i]) nlast++;
      checks++;
      if (got_last[i] !== ((i % 8) == 7)) begin
        errors++; $display("[TB] FAIL bp_last%0d: got %0b required %0b", i, got_last[i], ((i % 8) == 7));
      end
    end
    checks++;
    if (nlast !== 3) begin
      errors++; $display("[TB] FAIL bp_last_count: got %0d required 3", nlast);
    end
  endtask

  task automatic test_back_to_back();
    longint xs [$];
    longint exp_q [$];
    blk_t   x;
    blk_t   y;
    xs.delete(); exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        x[i] = rand_sample();
        xs.push_back(x[i]);
      end
      dct_ref(x, y);
      push_block(exp_q, y);
    end
    clear_got();
    m_ready = 1'b1;
    applyStimulus(xs, 0);
    wait_words(32);
    for (int i = 0; i < 32 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i]) begin
        errors++; $display("[TB] FAIL b2b_word%0d: got %0d required %0d", i, got_data[i], exp_q[i]);
      end
    end
    if (got_cyc.size() >= 32) begin
      checks++;
      if (got_cyc[31] - got_cyc[0] !== 31) begin
        errors++; $display("[TB] FAIL b2b_gapless: got span %0d required 31", got_cyc[31] - got_cyc[0]);
      end
    end
  endtask

  task automatic test_random_stall();
    longint xs [$];
    longint exp_q [$];
    blk_t   x;
    blk_t   y;
    xs.delete(); exp_q.delete();
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) begin
        x[i] = rand_sample();
        xs.push_back(x[i]);
      end
      dct_ref(x, y);
      push_block(exp_q, y);
    end
    clear_got();
    fork
      applyStimulus(xs, 30);
      begin
        for (int n = 0; n < 3000 && got_data.size() < 40; n++) begin
          @(posedge clk); #1 m_ready = ($urandom_range(99) < 55);
        end
        m_ready = 1'b1;
      end
    join
    wait_words(40);
    for (int i = 0; i < 40 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_q[i] || got_last[i] !== ((i % 8) == 7)) begin
        errors++; $display("[TB] FAIL stall_word%0d: got %0d/%0b required %0d/%0b",
                           i, got_data[i], got_last[i], exp_q[i], ((i % 8) == 7));
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    blk_t   x;
    blk_t   y;
    longint xs [$];
    xs.delete();
    for (int i = 0; i < 8; i++) begin
      x[i] = rand_sample();
      xs.push_back(x[i]);
    end
    dct_ref(x, y);
    clear_got();
    m_ready = 1'b1;
    applyStimulus(xs, 0);
    wait_words(8);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (got_data.size() !== 8) begin
      errors++; $display("[TB] FAIL %s_count: got %0d words required 8", tag, got_data.size());
    end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== y[i]) begin
        errors++; $display("[TB] FAIL %s_word%0d: got %0d required %0d", tag, i, got_data[i], y[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    longint xs [$];
    int     waited;
    // Reset after five samples of a block
    xs.delete();
    for (int i = 0; i < 5; i++) xs.push_back(rand_sample());
    m_ready = 1'b1;
    applyStimulus(xs, 0);
    reset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_in: got %0b/%0d/%0b required 0/0/0", m_valid, m_data, m_last);
    end
    @(posedge clk); #1 reset = 1'b1;
    checkOutput("rst_after_in");

    // Reset while word 3 is on the output
    xs.delete();
    for (int i = 0; i < 8; i++) xs.push_back(rand_sample());
    clear_got();
    applyStimulus(xs, 0);
    waited = 0;
    while (got_data.size() < 3 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (got_data.size() < 3) begin
      errors++; $display("[TB] FAIL rst_out_wait: got %0d words required 3", got_data.size());
    end
    @(posedge clk); #1 reset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== '0 || m_last !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_out: got %0b/%0d/%0b required 0/0/0", m_valid, m_data, m_last);
    end
    @(posedge clk); #1 reset = 1'b1;
    checkOutput("rst_after_out");
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_random_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
